// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared state encoding and default geometry for the
// switch-driven program loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package program_loader_pkg;

  localparam int DEF_DATA_W          = 8;
  localparam int DEF_ADDR_W          = 5;
  localparam int DEF_DEPTH           = 32;
  localparam int DEF_DEBOUNCE_CYCLES = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_WRITE,
    S_FULL,
    S_DONE
  } state_t;

endpackage

// File: rtl/program_loader_switch_sync.sv
// switch_sync: 2-flop synchroniser for one board switch, with an optional
// stability filter (macro PROGRAM_LOADER_DEBOUNCE_EN).
// Latency: 2 cycles; +DEBOUNCE_CYCLES when the filter is built in.
// Backpressure: none; level in, level out.
// Ports: clock, reset (sync, active-high), async_in (raw switch),
//        sync_out (clean level for the FSM).
module switch_sync
  import program_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta;
  logic raw;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= 1'b0;
      raw  <= 1'b0;
    end else begin
      meta <= async_in;
      raw  <= meta;
    end
  end

  // A zero-length filter makes no sense; this block exists only to tie the
  // parameter to the design in every build.
  if (DEBOUNCE_CYCLES < 1) begin : g_debounce_range
  end

`ifdef PROGRAM_LOADER_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] stable_cnt;
  logic             stable;

  // The output follows raw only after raw has differed from it for
  // DEBOUNCE_CYCLES consecutive samples; any return to agreement restarts.
  always_ff @(posedge clock) begin
    if (reset) begin
      stable_cnt <= '0;
      stable     <= 1'b0;
    end else if (raw == stable) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      stable_cnt <= '0;
      stable     <= raw;
    end else begin
      stable_cnt <= stable_cnt + CNT_W'(1);
    end
  end

  assign sync_out = stable;
`else
  assign sync_out = raw;
`endif

endmodule

// File: rtl/program_loader.sv
// program_loader: loads the instruction/data RAM one switch byte per enter
// press while load_mode is high, holding the CPU, then pulses run_start.
// Latency: enter rise -> mem_we 2 cycles after first sample; load_mode fall
// -> run_start 2 cycles after first sample (each +DEBOUNCE_CYCLES when
// PROGRAM_LOADER_DEBOUNCE_EN is defined).
// Backpressure: none; presses arriving in FULL are dropped.
// Ports: clock, reset (sync, active-high); load_mode, enter, data_in from the
//        switches; mem_we/mem_addr/mem_wdata to the RAM write port; cpu_hold,
//        run_start, done, full, load_count as status to the control unit.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int DATA_W          = DEF_DATA_W,
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int DEPTH           = DEF_DEPTH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_mode,
  input  logic              enter,
  input  logic [DATA_W-1:0] data_in,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              run_start,
  output logic              done,
  output logic              full,
  output logic [ADDR_W:0]   load_count
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W + 1)'(DEPTH - 1);

  logic   lm_s;
  logic   en_s;
  state_t state;
  state_t state_nxt;

  switch_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sync_lm (
    .clock    (clock),
    .reset    (reset),
    .async_in (load_mode),
    .sync_out (lm_s)
  );

  switch_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sync_en (
    .clock    (clock),
    .reset    (reset),
    .async_in (enter),
    .sync_out (en_s)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      load_count <= '0;
      done       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && state_nxt == S_ARM) begin
        mem_addr   <= '0;
        load_count <= '0;
        done       <= 1'b0;
      end
      if (state == S_WAIT && state_nxt == S_WRITE) begin
        mem_wdata <= data_in;
      end
      if (state == S_WRITE) begin
        load_count <= load_count + (ADDR_W + 1)'(1);
        // The last word leaves the address parked on the final location so a
        // power-of-two depth never wraps back to 0.
        if (load_count != LAST_C) begin
          mem_addr <= mem_addr + ADDR_W'(1);
        end
      end
      if (state_nxt == S_DONE) begin
        done <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    cpu_hold  = 1'b0;
    run_start = 1'b0;
    full      = (load_count == DEPTH_C);
    unique case (state)
      S_IDLE: begin
        if (lm_s) state_nxt = S_ARM;
      end
      S_ARM: begin
        cpu_hold = 1'b1;
        // An enter switch already high must be released before it counts.
        if (!lm_s)      state_nxt = S_DONE;
        else if (!en_s) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        cpu_hold = 1'b1;
        if (!lm_s)     state_nxt = S_DONE;
        else if (en_s) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        cpu_hold = 1'b1;
        mem_we   = 1'b1;
        if (!lm_s)                    state_nxt = S_DONE;
        else if (load_count == LAST_C) state_nxt = S_FULL;
        else                          state_nxt = S_ARM;
      end
      S_FULL: begin
        cpu_hold = 1'b1;
        if (!lm_s) state_nxt = S_DONE;
      end
      S_DONE: begin
        run_start = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed bench for program_loader; a cycle table for the
// basic load / release / restart flow plus sequences for full, enter-high,
// mid-write release, reset mid-write and (when built in) debounce.
module tb_program_loader;

`ifdef PROGRAM_LOADER_DEBOUNCE_EN
  localparam int DB = 16;
`else
  localparam int DB = 0;
`endif
  localparam int LAT  = 3 + DB;       // negedges from driving enter to mem_we
  localparam int HOLD = DB + 4;       // negedges enter is held high per press
  localparam int PW   = HOLD + DB + 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_mode;
  logic       enter;
  logic [7:0] data_in;
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       run_start;
  logic       done;
  logic       full;
  logic [5:0] load_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  program_loader dut (
    .clock      (clk),
    .reset      (reset),
    .load_mode  (load_mode),
    .enter      (enter),
    .data_in    (data_in),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .run_start  (run_start),
    .done       (done),
    .full       (full),
    .load_count (load_count)
  );

  // {we, addr, wdata, hold, run, done, full, count}
  function automatic logic [23:0] outs();
    return {mem_we, mem_addr, mem_wdata, cpu_hold, run_start, done, full, load_count};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Holds enter for HOLD negedges and watches for the resulting write.
  task automatic do_press(input string nm, input logic [7:0] d, input bit exp_wr,
                          input logic [4:0] exp_addr);
    int nwe = 0;
    int idx = -1;
    logic [4:0] a = '0;
    logic [7:0] w = '0;
    data_in = d;
    enter   = 1'b1;
    for (int i = 1; i <= PW; i++) begin
      @(negedge clk);
      if (mem_we) begin
        nwe++;
        if (idx < 0) begin
          idx = i; a = mem_addr; w = mem_wdata;
        end
      end
      if (i == HOLD) enter = 1'b0;
    end
    if (exp_wr) begin
      chk({nm, "_we_count"}, nwe, 1);
      chk({nm, "_we_latency"}, idx, LAT);
      chk({nm, "_addr"}, {27'd0, a}, {27'd0, exp_addr});
      chk({nm, "_wdata"}, {24'd0, w}, {24'd0, d});
    end else begin
      chk({nm, "_no_write"}, nwe, 0);
    end
  endtask

  task automatic release_check(input string nm, input logic [5:0] exp_cnt);
    int nrun = 0;
    int idx = -1;
    logic d_at = 1'b0;
    logic h_at = 1'b1;
    load_mode = 1'b0;
    for (int i = 1; i <= 8 + DB; i++) begin
      @(negedge clk);
      if (run_start) begin
        nrun++;
        if (idx < 0) begin
          idx = i; d_at = done; h_at = cpu_hold;
        end
      end
    end
    chk({nm, "_run_count"}, nrun, 1);
    chk({nm, "_run_latency"}, idx, 3 + DB);
    chk({nm, "_done_at_run"}, {31'd0, d_at}, 1);
    chk({nm, "_hold_at_run"}, {31'd0, h_at}, 0);
    chk({nm, "_count_after"}, {26'd0, load_count}, {26'd0, exp_cnt});
  endtask

  task automatic start_session(input string nm);
    load_mode = 1'b1;
    enter     = 1'b0;
    repeat (6 + 2 * DB) @(negedge clk);
    chk({nm, "_hold"}, {31'd0, cpu_hold}, 1);
    chk({nm, "_count"}, {26'd0, load_count}, 0);
    chk({nm, "_addr"}, {27'd0, mem_addr}, 0);
    chk({nm, "_done"}, {31'd0, done}, 0);
  endtask

`ifndef PROGRAM_LOADER_DEBOUNCE_EN
  typedef struct {
    logic        lm;
    logic        en;
    logic [7:0]  din;
    logic [23:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic lm, input logic en, input logic [7:0] din,
                              input logic we, input logic [4:0] a, input logic [7:0] wd,
                              input logic h, input logic r, input logic d, input logic f,
                              input logic [5:0] c);
    vec_t v;
    v.lm = lm; v.en = en; v.din = din;
    v.exp = {we, a, wd, h, r, d, f, c};
    return v;
  endfunction
`endif

  initial begin
    int nwe;
    int we_idx;
    int run_idx;
    logic [4:0] cap_a;
    logic [7:0] cap_w;
`ifndef PROGRAM_LOADER_DEBOUNCE_EN
    vec_t tbl[21];
    //                lm en din    we a  wd     h  r  d  f  cnt
    tbl[0]  = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 0);
    tbl[4]  = mk(1, 1, 8'hA5, 0, 0, 8'h00, 1, 0, 0, 0, 0);
    tbl[5]  = mk(1, 1, 8'hA5, 0, 0, 8'h00, 1, 0, 0, 0, 0);
    tbl[6]  = mk(1, 1, 8'hA5, 1, 0, 8'hA5, 1, 0, 0, 0, 0);
    tbl[7]  = mk(1, 0, 8'hA5, 0, 1, 8'hA5, 1, 0, 0, 0, 1);
    tbl[8]  = mk(1, 0, 8'hA5, 0, 1, 8'hA5, 1, 0, 0, 0, 1);
    tbl[9]  = mk(1, 1, 8'h3C, 0, 1, 8'hA5, 1, 0, 0, 0, 1);
    tbl[10] = mk(1, 1, 8'h3C, 0, 1, 8'hA5, 1, 0, 0, 0, 1);
    tbl[11] = mk(1, 1, 8'h3C, 1, 1, 8'h3C, 1, 0, 0, 0, 1);
    tbl[12] = mk(1, 0, 8'h3C, 0, 2, 8'h3C, 1, 0, 0, 0, 2);
    tbl[13] = mk(0, 0, 8'h3C, 0, 2, 8'h3C, 1, 0, 0, 0, 2);
    tbl[14] = mk(0, 0, 8'h3C, 0, 2, 8'h3C, 1, 0, 0, 0, 2);
    tbl[15] = mk(0, 0, 8'h3C, 0, 2, 8'h3C, 0, 1, 1, 0, 2);
    tbl[16] = mk(0, 0, 8'h3C, 0, 2, 8'h3C, 0, 0, 1, 0, 2);
    tbl[17] = mk(1, 0, 8'h3C, 0, 2, 8'h3C, 0, 0, 1, 0, 2);
    tbl[18] = mk(1, 0, 8'h3C, 0, 2, 8'h3C, 0, 0, 1, 0, 2);
    tbl[19] = mk(1, 0, 8'h3C, 0, 0, 8'h3C, 1, 0, 0, 0, 0);
    tbl[20] = mk(1, 0, 8'h3C, 0, 0, 8'h3C, 1, 0, 0, 0, 0);
`endif

    reset = 1'b1; load_mode = 1'b0; enter = 1'b0; data_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {8'd0, outs()}, 32'd0);
    reset = 1'b0;

`ifndef PROGRAM_LOADER_DEBOUNCE_EN
    // Basic load of A5/3C, release, restart: one row per clock.
    for (int i = 0; i < 21; i++) begin
      load_mode = tbl[i].lm;
      enter     = tbl[i].en;
      data_in   = tbl[i].din;
      @(negedge clk);
      chk($sformatf("table_row%0d", i), {8'd0, outs()}, {8'd0, tbl[i].exp});
    end
`else
    start_session("db_session");
    // A 10-cycle glitch must not reach the FSM.
    nwe = 0;
    data_in = 8'h11;
    enter = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (mem_we) nwe++;
      if (i == 10) enter = 1'b0;
    end
    chk("db_glitch_no_write", nwe, 0);
    do_press("db_press", 8'h77, 1'b1, 5'd0);
    release_check("db_release", 6'd1);
`endif

    // Fill all 32 words, then one extra press that must be dropped.
    start_session("full_session");
    for (int i = 0; i < 32; i++) begin
      do_press($sformatf("full_w%0d", i), 8'(i), 1'b1, 5'(i));
    end
    chk("full_flag", {31'd0, full}, 1);
    chk("full_count", {26'd0, load_count}, 32);
    chk("full_addr", {27'd0, mem_addr}, 31);
    do_press("full_extra", 8'd32, 1'b0, 5'd0);
    chk("full_extra_addr", {27'd0, mem_addr}, 31);
    chk("full_extra_count", {26'd0, load_count}, 32);
    release_check("full_release", 6'd32);
    chk("full_after_release", {31'd0, full}, 1);

    // Enter load mode with enter already high: no write until re-pressed.
    nwe = 0;
    data_in = 8'hC3;
    enter = 1'b1;
    load_mode = 1'b1;
    for (int i = 0; i < 10 + 2 * DB; i++) begin
      @(negedge clk);
      if (mem_we) nwe++;
    end
    chk("enter_high_no_write", nwe, 0);
    chk("enter_high_hold", {31'd0, cpu_hold}, 1);
    enter = 1'b0;
    repeat (6 + DB) @(negedge clk);
    do_press("enter_high_repress", 8'h96, 1'b1, 5'd0);

    // Drop load_mode one cycle after enter so it lands while in WRITE.
    nwe = 0; we_idx = -1; run_idx = -1; cap_a = '0; cap_w = '0;
    data_in = 8'h5A;
    enter = 1'b1;
    @(negedge clk);
    load_mode = 1'b0;
    for (int i = 2; i <= PW; i++) begin
      @(negedge clk);
      if (mem_we) begin
        nwe++;
        if (we_idx < 0) begin we_idx = i; cap_a = mem_addr; cap_w = mem_wdata; end
      end
      if (run_start) begin
        if (run_idx < 0) run_idx = i; else run_idx = 99;
      end
      if (i == HOLD) enter = 1'b0;
    end
    chk("midwrite_we_count", nwe, 1);
    chk("midwrite_we_latency", we_idx, LAT);
    chk("midwrite_addr", {27'd0, cap_a}, 1);
    chk("midwrite_wdata", {24'd0, cap_w}, 32'h5A);
    chk("midwrite_run_once_after", run_idx, LAT + 1);
    chk("midwrite_done", {31'd0, done}, 1);
    chk("midwrite_count", {26'd0, load_count}, 2);

    // Reset landing in the WRITE cycle.
    start_session("rst_session");
    data_in = 8'hE7;
    enter = 1'b1;
    we_idx = -1;
    for (int i = 1; i <= LAT + 3 && we_idx < 0; i++) begin
      @(negedge clk);
      if (mem_we) we_idx = i;
    end
    chk("rst_reached_write", we_idx, LAT);
    reset = 1'b1; load_mode = 1'b0; enter = 1'b0;
    @(negedge clk);
    chk("rst_midwrite_outputs", {8'd0, outs()}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stays_idle", {8'd0, outs()}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Sequencer that loads a program into the processor's 32x8 instruction/data RAM from the board switches before execution starts. While `load_mode` is high it holds the CPU, takes one byte per `enter` press, writes it to the next RAM address, and counts the words loaded. When `load_mode` drops it releases the CPU and issues a one-cycle `run_start` to the control unit. It sits between the switch inputs and the datapath's RAM write port, ahead of the CU/DataPath pair in the processor top.

## Interface
- `DATA_W`, 8, RAM word width.
- `ADDR_W`, 5, RAM address width.
- `DEPTH`, 32, number of loadable words; must be ≤ 2^ADDR_W.
- `DEBOUNCE_CYCLES`, 16, stable-sample count; used only with `PROGRAM_LOADER_DEBOUNCE_EN`.

Ports:
- `clock` in 1: single clock for the whole block.
- `reset` in 1: synchronous, active-high.
- `load_mode` in 1: asynchronous switch level; high requests load mode.
- `enter` in 1: asynchronous switch level; a low→high transition commits one byte.
- `data_in` in DATA_W: switch byte. It must be quasi-static when `enter` rises.
- `mem_we` out 1: RAM write enable, one-cycle pulse.
- `mem_addr` out ADDR_W: RAM write address.
- `mem_wdata` out DATA_W: RAM write data.
- `cpu_hold` out 1: high while loading; the CU must not advance.
- `run_start` out 1: one-cycle pulse when loading ends.
- `done` out 1: sticky; high once a load session has completed.
- `full` out 1: high when DEPTH words have been written this session.
- `load_count` out ADDR_W+1: number of words written this session, range 0..DEPTH.

## Operation
- **Input synchronisation.** `load_mode` and `enter` each pass through a 2-flop synchroniser. All decisions use the synchronised values (`lm_s`, `en_s`).
- **States:**
  - IDLE → ARM when `lm_s`=1.
  - ARM: waits for `en_s`=0, then → WAIT. This rejects an `enter` switch already high on entry.
  - WAIT: on `en_s`=1, capture `data_in` into `mem_wdata` and go → WRITE.
  - WRITE: `mem_we`=1 for one cycle. At the end of the cycle, `mem_addr`+1 and `load_count`+1. Next state is FULL if `load_count` reaches DEPTH, else ARM.
  - FULL: `full`=1. Further `enter` edges are ignored; no write and no address change.
  - DONE: entered from ARM, WAIT or FULL when `lm_s`=0. Pulses `run_start` on the transition cycle, holds `done`=1 and `cpu_hold`=0, then → IDLE with `done` still held.
- **Leaving load mode mid-write.** If `lm_s` falls while in WRITE, the write completes first, then the FSM goes → DONE.
- **Starting a new session.** Entering ARM from IDLE clears `mem_addr`, `load_count`, `full` and `done`.
- **Empty session.** Leaving load mode with zero words still pulses `run_start`, with `load_count`=0.
- **Address wrap.** `mem_addr` never wraps within a session. When DEPTH=2^ADDR_W, `mem_addr` is left at DEPTH-1 in FULL.
- **`cpu_hold`** is 1 in ARM, WAIT, WRITE and FULL, and 0 otherwise.
- **Reset.** Synchronous reset in any state, including mid-write, forces IDLE. `mem_we` is 0 from the next cycle.
- **Reset values:** all outputs 0, `mem_addr`=0, `load_count`=0, synchroniser flops 0.

## Timing
- **`enter` to write.** `enter` first sampled high at edge k: `en_s` is valid after edge k+1, the FSM enters WRITE at edge k+2, and `mem_we` is high from k+2 to k+3. The RAM commits at edge k+3. `mem_addr` and `mem_wdata` are stable for the whole `mem_we` cycle.
- **`load_mode` fall to `run_start`.** `load_mode` first sampled low at edge k: `run_start` is high from edge k+2 to k+3, and `cpu_hold` is low from edge k+2.
- **Debounce latency.** With debounce enabled, add DEBOUNCE_CYCLES to both latencies above.
- **Write rate.** Minimum press-to-press spacing is 4 cycles: WRITE→ARM→(`en_s` low)→WAIT.

## Configuration
- **`PROGRAM_LOADER_DEBOUNCE_EN` defined.** After synchronisation, `en_s` and `lm_s` change only after the raw synchronised value has been stable for DEBOUNCE_CYCLES consecutive cycles. The stability counter restarts on any change. Glitches shorter than DEBOUNCE_CYCLES produce no write.
- **Not defined.** Synchroniser only; every clean low→high transition on `enter` produces one write.

## Structure
- **Shared package `program_loader_pkg`:** state enum (IDLE, ARM, WAIT, WRITE, FULL, DONE), default DATA_W, ADDR_W and DEPTH constants.
- **Sub-module `switch_sync`:** one instance per switch input, containing the 2-flop synchroniser plus the optional debounce counter (macro-guarded). The FSM and counters live in the top of this block.

## Test plan
- **Basic load.** Reset; `load_mode`=1; press `enter` with `data_in`=0xA5 then 0x3C. Expect two `mem_we` pulses: addr 0 → 0xA5, addr 1 → 0x3C. `load_count`=2, `cpu_hold`=1.
- **Release and restart.** From the basic-load state, drop `load_mode`. Expect `run_start` exactly one cycle, 2 cycles after sampling, with `done`=1 and `cpu_hold`=0. Re-assert `load_mode`: `done`=0, `mem_addr`=0, `load_count`=0.
- **Full.** Issue 33 presses with `data_in`=index. Expect 32 writes at addrs 0..31 with matching data, then `full`=1. The 33rd press produces no `mem_we` and `mem_addr` stays 31.
- **Enter already high.** Enter load mode with `enter` already high. Expect no write until `enter` goes low then high. Separately, drop `load_mode` during WRITE: the write completes, then exactly one `run_start`.
- **Reset mid-write.** Assert `reset` in the WRITE cycle. Next cycle: `mem_we`=0, all outputs 0, state IDLE.
- **Debounce (`PROGRAM_LOADER_DEBOUNCE_EN`, DEBOUNCE_CYCLES=16).** A 10-cycle `enter` glitch produces no write. A 20-cycle press produces one write, at edge k+2+16.
